cep_pkt_packer: RTL and testbench
=================================

# cep_pkt_packer

Sequential, parametrised CEP packet packer that sits between the chip-bridge message source and the inter-chip link serializer. It accepts one coherence message per valid/ready handshake, with header fields and up to `MAX_DATA_WORDS` payload words. It emits that message as one or more `CEP_WORDS*WORD_W`-bit CEP packets, numbering them through `subline_id` and flagging the final one with `last_subline`. Unlike a single-packet combinational encoder, it splits payloads larger than one packet's capacity and applies output back-pressure.

## Interface
- `WORD_W`, 64, CEP word width in bits.
- `CEP_WORDS`, 8, words per CEP packet; must be ≥ 4.
- `MAX_DATA_WORDS`, 16, maximum payload words per input message.
- `clk` input 1: the single clock; all state is registered on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_val` input 1: input message valid.
- `in_rdy` output 1: packer can accept a message.
- `in_is_request` input 1: 1 selects request format, 0 selects response format.
- `in_mesi`, `in_mshrid`, `in_msg_type`, `in_data_size`, `in_cache_type`, `in_subline_vector`, `in_addr`, `in_src_chipid`: inputs, each sized by its `CEP_*_WIDTH` macro. These are the header fields.
- `in_length` input `$clog2(MAX_DATA_WORDS+1)`: number of valid payload words.
- `in_data` input `MAX_DATA_WORDS*WORD_W`: payload; word 0 is at the LSBs.
- `out_val` output 1: a CEP packet is valid.
- `out_rdy` input 1: downstream accepts the packet.
- `out_pkg` output `CEP_WORDS*WORD_W`: the CEP packet.
- `err_len` output 1: one-cycle pulse when an accepted message had `in_length > MAX_DATA_WORDS`.

## Operation
- Header words:
  - A request uses words 0..2; its capacity `CAP_REQ = CEP_WORDS-3`.
  - A response uses word 0; its capacity `CAP_RSP = CEP_WORDS-1`.
- All `CEP_*` field macros locate fields within the header words, unchanged from the existing format.
- Request-only fields (`data_size`, `cache_type`, `subline_vector`, `addr`, `src_chipid`) are zero in response packets.
- `CEP_IS_REQ` is set from `in_is_request`.
- Beat count: `NB = max(1, ceil(L/CAP))`, where `L` is `in_length` clamped to `MAX_DATA_WORDS`.
- Beat `k` (0-based) carries payload words `k*CAP .. min(L, (k+1)*CAP)-1`.
  - These fill the packet's data slots in ascending order, starting at the first word after the header.
  - Unused data slots are zero.
- Per beat:
  - `subline_id = k`.
  - `last_subline = (k == NB-1)`.
  - The `length` field is the number of data words in this beat; 0 is legal and occurs when `L = 0`.
  - `mesi`, `mshrid` and `msg_type` are repeated unchanged on every beat.
- FSM states:
  - IDLE:
    - `in_rdy = 1`.
    - On `in_val`, capture all inputs, build beat 0 into `out_pkg`, and go to SEND.
  - SEND:
    - `out_val = 1`.
    - On `out_rdy` with a non-final beat: load beat `k+1` and stay in SEND.
    - On `out_rdy` with the final beat: if `in_val`, capture the new message and load its beat 0, staying in SEND; otherwise go to IDLE.
- `in_rdy = (state == IDLE) | (out_val & out_rdy & last_subline)`.
- Length overflow: `in_length > MAX_DATA_WORDS` is clamped to `MAX_DATA_WORDS`, and `err_len` pulses in the cycle after capture.

## Timing
- Reset values: state IDLE; `out_val = 0`; `out_pkg = 0`; `err_len = 0`; beat counter 0; `in_rdy = 1`.
- Latency: a message accepted at edge `t` presents beat 0 with `out_val = 1` after edge `t`, i.e. one cycle of latency.
- `out_pkg` is registered and stays stable while `out_val & ~out_rdy`; stalls of any length are legal.
- Throughput is one beat per cycle, with no bubble between messages when the final beat and the next message complete on the same edge.
- Simultaneous final-beat completion and `in_val` at the same edge: the new message is captured and the old one is retired, with no loss and no duplication.
- Reset asserted mid-message: the in-flight message is dropped, and `out_val` falls asynchronously.
- Beat counter width: `$clog2(ceil(MAX_DATA_WORDS/CAP_RSP... CAP_REQ)+1)`, sized for the worst case `CAP_REQ`; it never wraps within a message.

## Structure
- Shared `cep_defines.vh` additions: `CEP_REQ_HDR_WORDS` (3) and `CEP_RSP_HDR_WORDS` (1).
- Existing field macros are reused unchanged.
- Sub-module `cep_beat_builder`: a combinational block that takes captured fields, the beat index `k` and the format, and produces one packet.
  - It is instantiated once; the FSM and registers stay in the top module.

## Test plan
- Response, `L = 3`, `out_rdy = 1`:
  - One beat with `subline_id = 0`, `last_subline = 1`, `length = 3`.
  - Words 1..3 carry data; words 4..7 are zero.
- Request, `L = 12` (`CAP_REQ = 5`):
  - Three beats with lengths 5, 5, 2 and `subline_id` 0, 1, 2; `last_subline` is set only on the third.
  - `addr` is identical on all beats.
- Request, `L = 0`: one beat with `length = 0` and all data slots zero.
- Back-to-back: two response messages with `L = 7`, `in_val` held high, `out_rdy = 1` → beats on consecutive cycles with no idle cycle.
- Stall: `out_rdy = 0` for 5 cycles mid-message → `out_pkg` unchanged throughout, and `in_rdy = 0` throughout.
- Error and reset:
  - `in_length = 20` → data clamped to 16 words; `err_len` high for exactly 1 cycle.
  - `rst_n` low during beat 1 → `out_val = 0` immediately; after release, state is IDLE and `in_rdy = 1`.

Source files
------------

// File: rtl/cep_pkt_packer_pkg.sv
// CEP field map, captured-header struct and FSM encoding shared by the packer files.
// No logic, no latency, no backpressure.
`ifndef CEP_DEFINES_VH
`define CEP_DEFINES_VH
`define CEP_MESI_WIDTH           2
`define CEP_MSHRID_WIDTH         8
`define CEP_MSG_TYPE_WIDTH       8
`define CEP_DATA_SIZE_WIDTH      3
`define CEP_CACHE_TYPE_WIDTH     1
`define CEP_SUBLINE_VECTOR_WIDTH 4
`define CEP_ADDR_WIDTH           48
`define CEP_SRC_CHIPID_WIDTH     8
`define CEP_SUBLINE_ID_WIDTH     4
`define CEP_LENGTH_WIDTH         5
// Word 0 of every packet
`define CEP_MSG_TYPE             7:0
`define CEP_MSHRID               15:8
`define CEP_MESI                 17:16
`define CEP_IS_REQ               18
`define CEP_LAST_SUBLINE         19
`define CEP_SUBLINE_ID           23:20
`define CEP_LENGTH               28:24
`define CEP_DATA_SIZE            31:29
`define CEP_CACHE_TYPE           32
`define CEP_SUBLINE_VECTOR       36:33
// Word 1 / word 2 of request packets
`define CEP_ADDR                 47:0
`define CEP_SRC_CHIPID           7:0
`define CEP_REQ_HDR_WORDS        3
`define CEP_RSP_HDR_WORDS        1
`endif

package cep_pkt_packer_pkg;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    typedef struct packed {
        logic                                 is_req;
        logic [`CEP_MESI_WIDTH-1:0]           mesi;
        logic [`CEP_MSHRID_WIDTH-1:0]         mshrid;
        logic [`CEP_MSG_TYPE_WIDTH-1:0]       msg_type;
        logic [`CEP_DATA_SIZE_WIDTH-1:0]      data_size;
        logic [`CEP_CACHE_TYPE_WIDTH-1:0]     cache_type;
        logic [`CEP_SUBLINE_VECTOR_WIDTH-1:0] subline_vector;
        logic [`CEP_ADDR_WIDTH-1:0]           addr;
        logic [`CEP_SRC_CHIPID_WIDTH-1:0]     src_chipid;
    } hdr_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/cep_beat_builder.sv
// Builds one CEP packet (header + payload slice) for beat index k of a captured message.
// Purely combinational, zero latency; no backpressure of its own.
module cep_beat_builder
    import cep_pkt_packer_pkg::*;
#(
    parameter int WORD_W         = 64,
    parameter int CEP_WORDS      = 8,
    parameter int MAX_DATA_WORDS = 16,
    parameter int LEN_W          = 5,
    parameter int BEAT_W         = 3
) (
    input  hdr_t                             hdr,
    input  logic [LEN_W-1:0]                 len,
    input  logic [MAX_DATA_WORDS*WORD_W-1:0] data,
    input  logic [BEAT_W-1:0]                beat,
    output logic [CEP_WORDS*WORD_W-1:0]      pkt,
    output logic                             last
);

    localparam int CAP_REQ = CEP_WORDS - `CEP_REQ_HDR_WORDS;
    localparam int CAP_RSP = CEP_WORDS - `CEP_RSP_HDR_WORDS;

    logic [WORD_W-1:0] dword [MAX_DATA_WORDS];
    logic [WORD_W-1:0] w0, w1, w2, slot;
    int cap, hdr_words, base, cnt, idx;

    for (genvar i = 0; i < MAX_DATA_WORDS; i++) begin : g_dword
        assign dword[i] = data[i*WORD_W +: WORD_W];
    end

    always_comb begin
        cap       = hdr.is_req ? CAP_REQ : CAP_RSP;
        hdr_words = hdr.is_req ? `CEP_REQ_HDR_WORDS : `CEP_RSP_HDR_WORDS;
        base      = int'(beat) * cap;
        cnt       = (int'(len) > base) ? (int'(len) - base) : 0;
        if (cnt > cap) cnt = cap;
        last      = (base + cap >= int'(len));

        w0 = '0;
        w0[`CEP_MSG_TYPE]     = hdr.msg_type;
        w0[`CEP_MSHRID]       = hdr.mshrid;
        w0[`CEP_MESI]         = hdr.mesi;
        w0[`CEP_IS_REQ]       = hdr.is_req;
        w0[`CEP_LAST_SUBLINE] = last;
        w0[`CEP_SUBLINE_ID]   = `CEP_SUBLINE_ID_WIDTH'(beat);
        w0[`CEP_LENGTH]       = `CEP_LENGTH_WIDTH'(cnt);
        w1 = '0;
        w2 = '0;
        if (hdr.is_req) begin
            w0[`CEP_DATA_SIZE]      = hdr.data_size;
            w0[`CEP_CACHE_TYPE]     = hdr.cache_type;
            w0[`CEP_SUBLINE_VECTOR] = hdr.subline_vector;
            w1[`CEP_ADDR]           = hdr.addr;
            w2[`CEP_SRC_CHIPID]     = hdr.src_chipid;
        end

        pkt = '0;
        pkt[0 +: WORD_W] = w0;
        if (hdr.is_req) begin
            pkt[WORD_W +: WORD_W]   = w1;
            pkt[2*WORD_W +: WORD_W] = w2;
        end

        // Data slots: constant-index mux keeps the payload select free of wide index math.
        for (int s = 0; s < CEP_WORDS; s++) begin
            idx  = base + s - hdr_words;
            slot = '0;
            for (int j = 0; j < MAX_DATA_WORDS; j++) begin
                if (j == idx) slot = dword[j];
            end
            if (s >= hdr_words && (s - hdr_words) < cnt) begin
                pkt[s*WORD_W +: WORD_W] = slot;
            end
        end
    end

endmodule

// File: rtl/cep_pkt_packer.sv
// Splits one coherence message into CEP packets numbered by subline_id, last one flagged.
// One cycle accept-to-beat-0 latency, one beat/cycle; out_rdy low holds the beat and in_rdy.
module cep_pkt_packer
    import cep_pkt_packer_pkg::*;
#(
    parameter int WORD_W         = 64,
    parameter int CEP_WORDS      = 8,
    parameter int MAX_DATA_WORDS = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_val,
    output logic                                   in_rdy,
    input  logic                                   in_is_request,
    input  logic [`CEP_MESI_WIDTH-1:0]             in_mesi,
    input  logic [`CEP_MSHRID_WIDTH-1:0]           in_mshrid,
    input  logic [`CEP_MSG_TYPE_WIDTH-1:0]         in_msg_type,
    input  logic [`CEP_DATA_SIZE_WIDTH-1:0]        in_data_size,
    input  logic [`CEP_CACHE_TYPE_WIDTH-1:0]       in_cache_type,
    input  logic [`CEP_SUBLINE_VECTOR_WIDTH-1:0]   in_subline_vector,
    input  logic [`CEP_ADDR_WIDTH-1:0]             in_addr,
    input  logic [`CEP_SRC_CHIPID_WIDTH-1:0]       in_src_chipid,
    input  logic [$clog2(MAX_DATA_WORDS+1)-1:0]    in_length,
    input  logic [MAX_DATA_WORDS*WORD_W-1:0]       in_data,
    output logic                                   out_val,
    input  logic                                   out_rdy,
    output logic [CEP_WORDS*WORD_W-1:0]            out_pkg,
    output logic                                   err_len
);

    localparam int LEN_W   = $clog2(MAX_DATA_WORDS+1);
    localparam int CAP_REQ = CEP_WORDS - `CEP_REQ_HDR_WORDS;
    localparam int BEAT_W  = $clog2(ceil_div(MAX_DATA_WORDS, CAP_REQ) + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_WORDS);

    state_t                            state_q, state_d;
    hdr_t                              hdr_q, in_hdr, bld_hdr;
    logic [LEN_W-1:0]                  len_q, len_clamp, bld_len;
    logic [MAX_DATA_WORDS*WORD_W-1:0]  data_q, bld_data;
    logic [BEAT_W-1:0]                 beat_q, bld_beat;
    logic [CEP_WORDS*WORD_W-1:0]       pkt_q, bld_pkt;
    logic                              last_q, bld_last, err_q;
    logic                              load_new, advance;

    always_comb begin
        in_hdr                = '0;
        in_hdr.is_req         = in_is_request;
        in_hdr.mesi           = in_mesi;
        in_hdr.mshrid         = in_mshrid;
        in_hdr.msg_type       = in_msg_type;
        in_hdr.data_size      = in_data_size;
        in_hdr.cache_type     = in_cache_type;
        in_hdr.subline_vector = in_subline_vector;
        in_hdr.addr           = in_addr;
        in_hdr.src_chipid     = in_src_chipid;
        len_clamp             = (in_length > MAX_LEN) ? MAX_LEN : in_length;
    end

    always_comb begin
        state_d  = state_q;
        in_rdy   = 1'b0;
        out_val  = 1'b0;
        load_new = 1'b0;
        advance  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    load_new = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    if (!last_q) begin
                        advance = 1'b1;
                    end else begin
                        // Final beat leaving: the next message can slip in on the same edge.
                        in_rdy = 1'b1;
                        if (in_val) load_new = 1'b1;
                        else        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bld_hdr  = load_new ? in_hdr    : hdr_q;
        bld_len  = load_new ? len_clamp : len_q;
        bld_data = load_new ? in_data   : data_q;
        bld_beat = load_new ? '0        : beat_q + BEAT_W'(1);
    end

    cep_beat_builder #(
        .WORD_W         (WORD_W),
        .CEP_WORDS      (CEP_WORDS),
        .MAX_DATA_WORDS (MAX_DATA_WORDS),
        .LEN_W          (LEN_W),
        .BEAT_W         (BEAT_W)
    ) u_beat_builder (
        .hdr  (bld_hdr),
        .len  (bld_len),
        .data (bld_data),
        .beat (bld_beat),
        .pkt  (bld_pkt),
        .last (bld_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q  <= '0;
            len_q  <= '0;
            data_q <= '0;
            beat_q <= '0;
            pkt_q  <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= load_new && (in_length > MAX_LEN);
            if (load_new) begin
                hdr_q  <= in_hdr;
                len_q  <= len_clamp;
                data_q <= in_data;
                beat_q <= '0;
            end else if (advance) begin
                beat_q <= bld_beat;
            end
            if (load_new || advance) begin
                pkt_q  <= bld_pkt;
                last_q <= bld_last;
            end
        end
    end

    assign out_pkg = pkt_q;
    assign err_len = err_q;

endmodule

// File: tb/tb_cep_pkt_packer.sv
// Randomised + directed bench for cep_pkt_packer against a queue-of-packets reference model.
module tb_cep_pkt_packer;

    localparam int W    = 64;
    localparam int CW   = 8;
    localparam int MAXW = 16;
    localparam int LW   = 5;
    localparam int CAPQ = 5;
    localparam int CAPS = 7;

    typedef logic [CW*W-1:0] pkt_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_val = 1'b0;
    logic            in_rdy;
    logic            in_is_request = 1'b0;
    logic [1:0]      in_mesi = '0;
    logic [7:0]      in_mshrid = '0;
    logic [7:0]      in_msg_type = '0;
    logic [2:0]      in_data_size = '0;
    logic [0:0]      in_cache_type = '0;
    logic [3:0]      in_subline_vector = '0;
    logic [47:0]     in_addr = '0;
    logic [7:0]      in_src_chipid = '0;
    logic [LW-1:0]   in_length = '0;
    logic [MAXW*W-1:0] in_data = '0;
    logic            out_val;
    logic            out_rdy = 1'b0;
    pkt_t            out_pkg;
    logic            err_len;

    always #5 clk = ~clk;

    cep_pkt_packer #(.WORD_W(W), .CEP_WORDS(CW), .MAX_DATA_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy),
        .in_is_request(in_is_request), .in_mesi(in_mesi), .in_mshrid(in_mshrid),
        .in_msg_type(in_msg_type), .in_data_size(in_data_size), .in_cache_type(in_cache_type),
        .in_subline_vector(in_subline_vector), .in_addr(in_addr), .in_src_chipid(in_src_chipid),
        .in_length(in_length), .in_data(in_data), .out_val(out_val), .out_rdy(out_rdy),
        .out_pkg(out_pkg), .err_len(err_len)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   err_seen = 0;
    pkt_t exp_q[$];
    logic exp_last_q[$];
    pkt_t seen[$];
    logic exp_err = 1'b0;
    logic ev, er;

    task automatic chk1(input string n, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b at %0t", n, got, exp, $time);
        end
    endtask

    task automatic chki(input string n, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    task automatic chkw(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic chkp(input string n, input pkt_t got, input pkt_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_of(input pkt_t p, input int i);
        return p[i*W +: W];
    endfunction
    function automatic int f_len(input pkt_t p);  return int'(p[28:24]); endfunction
    function automatic int f_sub(input pkt_t p);  return int'(p[23:20]); endfunction
    function automatic int f_last(input pkt_t p); return int'(p[19]);    endfunction
    function automatic logic [W-1:0] din(input int i);
        return in_data[i*W +: W];
    endfunction

    // Reference: expand the message currently on the inputs into its expected beats.
    task automatic push_msg();
        int L, cap, hw, nb, cnt, hi;
        pkt_t p;
        logic [W-1:0] w0;
        L   = (int'(in_length) > MAXW) ? MAXW : int'(in_length);
        cap = in_is_request ? CAPQ : CAPS;
        hw  = in_is_request ? 3 : 1;
        nb  = (L == 0) ? 1 : (L + cap - 1) / cap;
        for (int k = 0; k < nb; k++) begin
            hi  = ((k + 1) * cap < L) ? (k + 1) * cap : L;
            cnt = hi - k * cap;
            w0 = '0;
            w0[7:0]   = in_msg_type;
            w0[15:8]  = in_mshrid;
            w0[17:16] = in_mesi;
            w0[18]    = in_is_request;
            w0[19]    = (k == nb - 1);
            w0[23:20] = k[3:0];
            w0[28:24] = cnt[4:0];
            if (in_is_request) begin
                w0[31:29] = in_data_size;
                w0[32]    = in_cache_type[0];
                w0[36:33] = in_subline_vector;
            end
            p = '0;
            p[W-1:0] = w0;
            if (in_is_request) begin
                p[2*W-1:W]   = {16'b0, in_addr};
                p[3*W-1:2*W] = {56'b0, in_src_chipid};
            end
            for (int j = 0; j < cnt; j++) p[(hw + j)*W +: W] = in_data[(k*cap + j)*W +: W];
            exp_q.push_back(p);
            exp_last_q.push_back(k == nb - 1);
        end
    endtask

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            exp_q.delete();
            exp_last_q.delete();
            exp_err = 1'b0;
            chk1("rst_out_val", out_val, 1'b0);
            chk1("rst_in_rdy", in_rdy, 1'b1);
            chk1("rst_err_len", err_len, 1'b0);
        end else begin
            ev = (exp_q.size() > 0);
            er = !ev || (out_rdy && exp_last_q[0]);
            chk1("out_val", out_val, ev);
            chk1("in_rdy", in_rdy, er);
            chk1("err_len", err_len, exp_err);
            if (err_len) err_seen++;
            if (ev) chkp("out_pkg", out_pkg, exp_q[0]);
            exp_err = 1'b0;
            if (ev && out_rdy) begin
                seen.push_back(out_pkg);
                void'(exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end
            if (in_val && er) begin
                push_msg();
                exp_err = (int'(in_length) > MAXW);
            end
        end
    end

    task automatic set_msg(input logic req, input int len);
        in_is_request     = req;
        in_length         = len[LW-1:0];
        in_mesi           = 2'($urandom);
        in_mshrid         = 8'($urandom);
        in_msg_type       = 8'($urandom);
        in_data_size      = 3'($urandom);
        in_cache_type     = 1'($urandom);
        in_subline_vector = 4'($urandom);
        in_addr           = {16'($urandom), $urandom};
        in_src_chipid     = 8'($urandom);
        for (int i = 0; i < MAXW; i++) in_data[i*W +: W] = {$urandom, $urandom};
    endtask

    // Call at a falling edge; returns at the falling edge after the accepting edge.
    task automatic send(input logic req, input int len);
        int n;
        set_msg(req, len);
        in_val = 1'b1;
        n = 0;
        #1;
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chki("accept_timeout", n, 0);
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chki("drain_timeout", n, 0);
        @(negedge clk);
    endtask

    pkt_t snap;
    int   e0;

    initial begin
        #2;
        chk1("reset_out_val", out_val, 1'b0);
        chk1("reset_in_rdy", in_rdy, 1'b1);
        chk1("reset_err_len", err_len, 1'b0);
        chkp("reset_out_pkg", out_pkg, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);

        // Response, L = 3
        seen.delete();
        send(1'b0, 3);
        drain();
        chki("rsp3_beats", seen.size(), 1);
        if (seen.size() == 1) begin
            chki("rsp3_len", f_len(seen[0]), 3);
            chki("rsp3_sub", f_sub(seen[0]), 0);
            chki("rsp3_last", f_last(seen[0]), 1);
            for (int s = 1; s <= 3; s++) chkw("rsp3_data", word_of(seen[0], s), din(s - 1));
            for (int s = 4; s < CW; s++) chkw("rsp3_zero", word_of(seen[0], s), '0);
        end

        // Request, L = 12
        seen.delete();
        send(1'b1, 12);
        drain();
        chki("req12_beats", seen.size(), 3);
        if (seen.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chki("req12_len", f_len(seen[k]), (k == 2) ? 2 : 5);
                chki("req12_sub", f_sub(seen[k]), k);
                chki("req12_last", f_last(seen[k]), (k == 2) ? 1 : 0);
                chkw("req12_addr", word_of(seen[k], 1), {16'b0, in_addr});
            end
            chkw("req12_b2w3", word_of(seen[2], 3), din(10));
            chkw("req12_b2w4", word_of(seen[2], 4), din(11));
            chkw("req12_b2w5", word_of(seen[2], 5), '0);
        end

        // Request, L = 0
        seen.delete();
        send(1'b1, 0);
        drain();
        chki("req0_beats", seen.size(), 1);
        if (seen.size() == 1) begin
            chki("req0_len", f_len(seen[0]), 0);
            chki("req0_last", f_last(seen[0]), 1);
            for (int s = 3; s < CW; s++) chkw("req0_zero", word_of(seen[0], s), '0);
        end

        // Back-to-back responses, L = 7
        seen.delete();
        set_msg(1'b0, 7);
        in_val = 1'b1;
        @(negedge clk);
        set_msg(1'b0, 7);
        #1;
        chk1("b2b_first_val", out_val, 1'b1);
        chk1("b2b_rdy", in_rdy, 1'b1);
        @(negedge clk);
        in_val = 1'b0;
        #1;
        chk1("b2b_second_val", out_val, 1'b1);
        chki("b2b_second_len", f_len(out_pkg), 7);
        drain();
        chki("b2b_beats", seen.size(), 2);

        // Stall during beat 1 of a request
        send(1'b1, 12);
        @(negedge clk);
        out_rdy = 1'b0;
        #1;
        snap = out_pkg;
        chki("stall_sub", f_sub(snap), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chkp("stall_pkg", out_pkg, snap);
            chk1("stall_in_rdy", in_rdy, 1'b0);
        end
        out_rdy = 1'b1;
        drain();

        // Over-length response is clamped to MAXW words
        seen.delete();
        e0 = err_seen;
        send(1'b0, 20);
        drain();
        chki("clamp_err_cycles", err_seen - e0, 1);
        chki("clamp_beats", seen.size(), 3);
        if (seen.size() == 3) begin
            chki("clamp_len0", f_len(seen[0]), 7);
            chki("clamp_len2", f_len(seen[2]), 2);
            chkw("clamp_w2", word_of(seen[2], 2), din(15));
            chkw("clamp_w3", word_of(seen[2], 3), '0);
        end

        // Reset mid-message, during beat 1
        send(1'b1, 12);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_out_val", out_val, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("post_rst_in_rdy", in_rdy, 1'b1);
        chk1("post_rst_out_val", out_val, 1'b0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            set_msg(1'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 20))
                                                              : int'($urandom_range(0, 16)));
            in_val  = 1'($urandom);
            out_rdy = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_val  = 1'b0;
        out_rdy = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
